// File: rtl/band_mixer_if.sv
// Band mixer bus: per-band sample inputs, gain programming port and the
// mixed-output / status signals. The master side drives samples and gains,
// the slave side is the mixer itself.
interface band_mixer_if #(
   parameter int NUM_BANDS = 16,
   parameter int IDX_WIDTH = $clog2(NUM_BANDS)
) ();
   logic [16*NUM_BANDS-1:0] band_data;
   logic [NUM_BANDS-1:0]    band_valid;
   logic                    gain_we;
   logic [IDX_WIDTH-1:0]    gain_addr;
   logic [7:0]              gain_data;
   logic                    overrun_clr;
   logic signed [15:0]      data_out;
   logic                    valid_out;
   logic                    clip;
   logic                    overrun;
   logic                    busy;

   modport master (
      output band_data, band_valid, gain_we, gain_addr, gain_data, overrun_clr,
      input  data_out, valid_out, clip, overrun, busy
   );

   modport slave (
      input  band_data, band_valid, gain_we, gain_addr, gain_data, overrun_clr,
      output data_out, valid_out, clip, overrun, busy
   );
endinterface

// File: rtl/band_mixer.sv
// Graphic-equalizer mixer: captures one 16-bit sample per band, weights each
// with a programmable Q1.7 gain through a single time-shared multiplier,
// then scales, saturates and emits one mono sample per complete frame.
module band_mixer #(
   parameter int NUM_BANDS = 16,
   parameter int OUT_SHIFT = 2,
   parameter int IDX_WIDTH = $clog2(NUM_BANDS)
) (
   input  logic        clk,
   input  logic        rst,
   band_mixer_if.slave bus
);
   localparam int DATA_W = 16;
   localparam int COEF_W = 8;
   localparam int PROD_W = DATA_W + COEF_W + 1;
   localparam int ACC_W  = PROD_W + IDX_WIDTH;
   localparam int SHIFT  = 7 + OUT_SHIFT;

   localparam logic [IDX_WIDTH-1:0]    LAST_IDX = IDX_WIDTH'(NUM_BANDS - 1);
   localparam logic [COEF_W-1:0]       UNITY    = 8'd128;
   localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'(2**(DATA_W-1) - 1);
   localparam logic signed [ACC_W-1:0] SAT_MIN  = ACC_W'(-(2**(DATA_W-1)));

   typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_SAT} state_t;

   // Clamp the scaled accumulator into the 16-bit output range.
   function automatic logic signed [DATA_W-1:0] sat_data(input logic signed [ACC_W-1:0] v);
      if (v > SAT_MAX) begin
         return SAT_MAX[DATA_W-1:0];
      end else if (v < SAT_MIN) begin
         return SAT_MIN[DATA_W-1:0];
      end
      return v[DATA_W-1:0];
   endfunction

   // True when the scaled accumulator lies outside the 16-bit range.
   function automatic logic sat_clip(input logic signed [ACC_W-1:0] v);
      return (v > SAT_MAX) || (v < SAT_MIN);
   endfunction

   state_t                    state_q, state_d;
   logic signed [DATA_W-1:0]  cap_q  [NUM_BANDS];
   logic signed [DATA_W-1:0]  cap_d  [NUM_BANDS];
   logic signed [DATA_W-1:0]  work_q [NUM_BANDS];
   logic signed [DATA_W-1:0]  work_d [NUM_BANDS];
   logic [COEF_W-1:0]         gain_q [NUM_BANDS];
   logic [COEF_W-1:0]         gain_d [NUM_BANDS];
   logic [NUM_BANDS-1:0]      pend_q, pend_d;
   logic signed [ACC_W-1:0]   acc_q, acc_d;
   logic [IDX_WIDTH-1:0]      idx_q, idx_d;
   logic signed [DATA_W-1:0]  dout_q, dout_d;
   logic                      valid_q, valid_d;
   logic                      clip_q, clip_d;
   logic                      ovr_q, ovr_d;

   logic                      snapshot;
   logic signed [PROD_W-1:0]  prod;
   logic signed [ACC_W-1:0]   scaled;

   // A frame starts only from IDLE once every band has delivered a sample.
   assign snapshot = (state_q == ST_IDLE) && (&pend_q);

   // Sample times gain as 9-bit signed (gain is unsigned Q1.7), 25-bit product.
   assign prod = PROD_W'(work_q[idx_q]) * PROD_W'($signed({1'b0, gain_q[idx_q]}));

   // Gain normalisation plus headroom shift; arithmetic, so it floors.
   assign scaled = acc_q >>> SHIFT;

   // Capture strobed samples; new strobes beat the snapshot clear of pending.
   // A strobe onto a still-pending band is an overrun unless that band is
   // being consumed by the snapshot on this very edge.
   always_comb begin
      cap_d  = cap_q;
      pend_d = pend_q;
      ovr_d  = ovr_q;
      if (snapshot) begin
         pend_d = '0;
      end
      for (int k = 0; k < NUM_BANDS; k++) begin
         if (bus.band_valid[k]) begin
            cap_d[k]  = bus.band_data[DATA_W*k +: DATA_W];
            pend_d[k] = 1'b1;
         end
      end
      if (bus.overrun_clr) begin
         ovr_d = 1'b0;
      end
      if (!snapshot && |(bus.band_valid & pend_q)) begin
         ovr_d = 1'b1;
      end
   end

   // Gain table write port; out-of-range addresses are dropped.
   always_comb begin
      gain_d = gain_q;
      if (bus.gain_we && (32'(bus.gain_addr) < NUM_BANDS)) begin
         gain_d[bus.gain_addr] = bus.gain_data;
      end
   end

   // Frame sequencer: snapshot, one multiply-accumulate per band, then
   // scale/saturate and strobe the result.
   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      acc_d   = acc_q;
      idx_d   = idx_q;
      dout_d  = dout_q;
      valid_d = 1'b0;
      clip_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (snapshot) begin
               work_d  = cap_q;
               acc_d   = '0;
               idx_d   = '0;
               state_d = ST_MAC;
            end
         end
         ST_MAC: begin
            acc_d = acc_q + ACC_W'(prod);
            if (idx_q == LAST_IDX) begin
               state_d = ST_SAT;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         ST_SAT: begin
            dout_d  = sat_data(scaled);
            clip_d  = sat_clip(scaled);
            valid_d = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset also restores unity gains.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         pend_q  <= '0;
         acc_q   <= '0;
         idx_q   <= '0;
         dout_q  <= '0;
         valid_q <= 1'b0;
         clip_q  <= 1'b0;
         ovr_q   <= 1'b0;
         for (int k = 0; k < NUM_BANDS; k++) begin
            cap_q[k]  <= '0;
            work_q[k] <= '0;
            gain_q[k] <= UNITY;
         end
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         acc_q   <= acc_d;
         idx_q   <= idx_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
         clip_q  <= clip_d;
         ovr_q   <= ovr_d;
         for (int k = 0; k < NUM_BANDS; k++) begin
            cap_q[k]  <= cap_d[k];
            work_q[k] <= work_d[k];
            gain_q[k] <= gain_d[k];
         end
      end
   end

   assign bus.data_out  = dout_q;
   assign bus.valid_out = valid_q;
   assign bus.clip      = clip_q;
   assign bus.overrun   = ovr_q;
   assign bus.busy      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_band_mixer.sv
// Directed bench for band_mixer: expected mixes are computed from a model of
// the captured samples and gains, queued at stimulus time and compared when
// valid_out fires.
module tb_band_mixer;
   localparam int NB = 16;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   band_mixer_if #(.NUM_BANDS(NB)) bus ();

   band_mixer #(.NUM_BANDS(NB), .OUT_SHIFT(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic signed [15:0] data;
      logic               clip;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   int   drv   [NB];
   int   cap_m [NB];
   int   gm    [NB];

   function automatic exp_t model();
      exp_t   r;
      longint acc;
      longint t;
      acc = 0;
      for (int k = 0; k < NB; k++) begin
         acc += longint'(cap_m[k]) * longint'(gm[k]);
      end
      t = acc >>> 9;
      if (t > 32767) begin
         r.data = 16'sd32767;
         r.clip = 1'b1;
      end else if (t < -32768) begin
         r.data = -16'sd32768;
         r.clip = 1'b1;
      end else begin
         r.data = 16'(t);
         r.clip = 1'b0;
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp();
      exp_q.push_back(model());
   endtask

   task automatic strobe(input logic [NB-1:0] mask);
      for (int k = 0; k < NB; k++) begin
         bus.band_data[16*k +: 16] = 16'(drv[k]);
         if (mask[k]) cap_m[k] = drv[k];
      end
      bus.band_valid = mask;
      tick();
      bus.band_valid = '0;
   endtask

   task automatic set_gain(input int a, input int g);
      bus.gain_we   = 1'b1;
      bus.gain_addr = 4'(a);
      bus.gain_data = 8'(g);
      tick();
      bus.gain_we   = 1'b0;
      gm[a]         = g;
   endtask

   task automatic wait_out(input string tag, input int budget, input int exp_lat);
      int   n;
      bit   seen;
      exp_t e;
      n    = 0;
      seen = 1'b0;
      while (n < budget && !seen) begin
         tick();
         n++;
         if (bus.valid_out === 1'b1) seen = 1'b1;
      end
      check({tag, " valid seen"}, 32'(seen), 1);
      if (seen) begin
         if (exp_lat > 0) check({tag, " latency"}, n, exp_lat);
         check({tag, " sb entry"}, 32'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, " data"}, 32'($signed(bus.data_out)), 32'(e.data));
            check({tag, " clip"}, 32'(bus.clip), 32'(e.clip));
         end
      end
   endtask

   task automatic fill(input int v);
      for (int k = 0; k < NB; k++) drv[k] = v;
   endtask

   initial begin
      int vcount;
      for (int k = 0; k < NB; k++) begin
         gm[k]    = 128;
         cap_m[k] = 0;
         drv[k]   = 0;
      end
      rst             = 1'b1;
      bus.band_data   = '0;
      bus.band_valid  = '0;
      bus.gain_we     = 1'b0;
      bus.gain_addr   = '0;
      bus.gain_data   = '0;
      bus.overrun_clr = 1'b0;
      tick();
      tick();
      check("reset data_out", 32'($signed(bus.data_out)), 0);
      check("reset valid_out", 32'(bus.valid_out), 0);
      check("reset clip", 32'(bus.clip), 0);
      check("reset overrun", 32'(bus.overrun), 0);
      check("reset busy", 32'(bus.busy), 0);
      rst = 1'b0;
      tick();

      // Unity gains, all bands 1000
      fill(1000);
      strobe('1);
      push_exp();
      check("unity busy idle before snapshot", 32'(bus.busy), 0);
      wait_out("unity", 40, 18);
      check("unity valid one cycle", 32'(bus.valid_out), 1);
      tick();
      check("unity valid drops", 32'(bus.valid_out), 0);
      check("unity clip drops", 32'(bus.clip), 0);
      check("unity data holds", 32'($signed(bus.data_out)), 4000);

      // Single band at half gain, then floor rounding of a negative value
      set_gain(3, 64);
      fill(0);
      drv[3] = 4096;
      strobe('1);
      push_exp();
      wait_out("gain half pos", 40, 18);
      drv[3] = -4097;
      strobe('1);
      push_exp();
      wait_out("gain half neg", 40, 18);
      set_gain(3, 128);

      // Saturation both ways at maximum gain
      for (int k = 0; k < NB; k++) set_gain(k, 255);
      fill(32767);
      strobe('1);
      push_exp();
      wait_out("sat pos", 40, 18);
      fill(-32768);
      strobe('1);
      push_exp();
      wait_out("sat neg", 40, 18);
      for (int k = 0; k < NB; k++) set_gain(k, 128);

      // Staggered arrival: band 15 five cycles after the rest
      for (int k = 0; k < NB; k++) drv[k] = k * 300 - 2000;
      strobe(16'h7FFF);
      for (int i = 0; i < 4; i++) tick();
      check("stagger waits for band 15", 32'(bus.busy), 0);
      strobe(16'h8000);
      push_exp();
      wait_out("stagger", 40, 18);
      check("stagger no overrun", 32'(bus.overrun), 0);

      // Overrun: band 2 strobed repeatedly before band 15, newest wins
      for (int k = 0; k < NB; k++) drv[k] = 50 * k + 7;
      strobe(16'h7FFF);
      drv[2] = 1111;
      strobe(16'h0004);
      check("overrun set", 32'(bus.overrun), 1);
      drv[2] = -2222;
      bus.overrun_clr = 1'b1;
      strobe(16'h0004);
      bus.overrun_clr = 1'b0;
      check("overrun set beats clear", 32'(bus.overrun), 1);
      drv[15] = 333;
      strobe(16'h8000);
      push_exp();
      wait_out("overrun frame", 40, 18);
      bus.overrun_clr = 1'b1;
      tick();
      bus.overrun_clr = 1'b0;
      check("overrun cleared", 32'(bus.overrun), 0);

      // Back-to-back: second full frame delivered during MAC
      for (int k = 0; k < NB; k++) drv[k] = 1000 - 90 * k;
      strobe('1);
      push_exp();
      for (int i = 0; i < 5; i++) tick();
      check("b2b busy in MAC", 32'(bus.busy), 1);
      for (int k = 0; k < NB; k++) drv[k] = -700 + 45 * k;
      strobe('1);
      push_exp();
      wait_out("b2b first", 40, 0);
      wait_out("b2b second", 40, 0);
      check("b2b no overrun", 32'(bus.overrun), 0);

      // Snapshot collision: band 0 strobed on the snapshot edge
      for (int k = 0; k < NB; k++) drv[k] = 200 + 10 * k;
      strobe('1);
      push_exp();
      drv[0] = 9000;
      strobe(16'h0001);
      wait_out("collision old frame", 40, 0);
      for (int k = 1; k < NB; k++) drv[k] = -100 * k;
      strobe(16'hFFFE);
      push_exp();
      wait_out("collision new band0", 40, 18);

      // Reset in the middle of MAC discards the frame and restores gains
      set_gain(5, 32);
      fill(0);
      drv[5] = 4096;
      strobe('1);
      for (int i = 0; i < 5; i++) tick();
      rst = 1'b1;
      #1;
      check("midreset data_out", 32'($signed(bus.data_out)), 0);
      check("midreset valid_out", 32'(bus.valid_out), 0);
      check("midreset clip", 32'(bus.clip), 0);
      check("midreset busy", 32'(bus.busy), 0);
      tick();
      rst = 1'b0;
      for (int k = 0; k < NB; k++) begin
         gm[k]    = 128;
         cap_m[k] = 0;
      end
      vcount = 0;
      for (int i = 0; i < 25; i++) begin
         tick();
         if (bus.valid_out !== 1'b0) vcount++;
      end
      check("midreset no valid_out", vcount, 0);
      fill(0);
      drv[5] = 4096;
      strobe('1);
      push_exp();
      wait_out("post reset gain", 40, 18);

      check("scoreboard drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/band_mixer.md
Name: band_mixer

Overview:
- Sums the per-band playback samples into one mono PCM stream.
- Sits directly downstream of the NUM_BANDS band playback instances and upstream of the audio output/DAC path.
- Captures each band's 16-bit sample on its valid strobe and applies a programmable per-band gain, so it acts as a graphic equalizer.
- Accumulates over a single time-multiplexed multiplier, then scales and saturates to 16 bits.
- Runs on the 4.4 MHz clock, with a 44 kHz frame rate, giving 100 clocks of budget per frame.

Parameters:
- NUM_BANDS, 16, number of band inputs. Range 2..32.
- OUT_SHIFT, 2, extra arithmetic right shift for headroom, applied after the gain normalisation shift.
- IDX_WIDTH, $clog2(NUM_BANDS), width of the band index.

Ports:
- clk  in  1  system clock, 4.4 MHz.
- rst  in  1  reset, asynchronous, active-high.
- band_data  in  16*NUM_BANDS  packed signed samples; band k is bits [16k+15:16k].
- band_valid  in  NUM_BANDS  1-cycle strobe per band; capture band_data slice k.
- gain_we  in  1  gain register write enable.
- gain_addr  in  IDX_WIDTH  band index for the write.
- gain_data  in  8  unsigned gain, Q1.7; 128 = unity, 0 = mute, 255 ≈ 1.99.
- overrun_clr  in  1  clears the overrun flag.
- data_out  out  16  signed mixed sample.
- valid_out  out  1  1-cycle strobe when data_out updates.
- clip  out  1  1-cycle strobe, coincident with valid_out, when saturation occurred.
- overrun  out  1  sticky flag: a band delivered a new sample before its previous one was consumed.
- busy  out  1  high while the FSM is not IDLE.

Behaviour:
- Reset values:
  - data_out=0, valid_out=0, clip=0, overrun=0, busy=0.
  - All capture registers, pending bits and accumulator = 0.
  - All gains = 128.
  - FSM = IDLE.
- Capture:
  - On band_valid[k], capture reg k <= slice k and pending[k] <= 1.
  - If pending[k] is already 1 and has not been consumed, overrun <= 1 and the sample is overwritten (newest wins).
- Gains:
  - gain_we writes gain[gain_addr] at the clock edge and takes effect immediately.
  - Within a frame, band k uses the gain value held on its MAC cycle.
  - gain_addr >= NUM_BANDS is ignored.
- overrun_clr clears overrun. If an overrun event occurs in the same cycle, the set wins.
- FSM states: IDLE, MAC, SAT.
  - IDLE, when pending is all-ones: snapshot all capture regs into working regs, clear pending, acc <= 0, idx <= 0, go to MAC.
  - If band_valid[k] arrives on the snapshot edge, the snapshot takes the old capture value. The new value is captured and pending[k] stays 1 for the next frame (set beats clear).
  - MAC, one band per cycle:
    - acc <= acc + working[idx] * signed({1'b0, gain[idx]}).
    - The product is 25-bit signed; acc width is 25+IDX_WIDTH.
    - After idx = NUM_BANDS-1, go to SAT.
  - SAT:
    - t = acc >>> (7+OUT_SHIFT), an arithmetic shift that rounds toward −inf.
    - Saturate t to [−32768, 32767] and assign it to data_out.
    - valid_out <= 1, and clip <= 1 if saturated.
    - Go to IDLE.
- A full frame arriving during MAC or SAT is held in pending and starts on the next IDLE evaluation. No frame is dropped unless an overrun occurs.
- Latency, with edge E0 being the capture of the last missing band:
  - Snapshot at E1.
  - MAC at E2..E(NUM_BANDS+1).
  - data_out/valid_out update at E(NUM_BANDS+2).
  - That is NUM_BANDS+2 edges, 18 for the default.
- valid_out and clip are high for exactly one cycle, otherwise 0. data_out holds its value between frames.
- busy = (state != IDLE).
- Reset asserted mid-operation immediately forces all reset values, including the gains. A partial frame is discarded and there is no valid_out for it.

Test Plan:
- Unity sum: all 16 bands = 1000 with simultaneous band_valid, gains at their reset value -> valid_out 18 edges later, data_out = 4000, clip = 0.
- Single band with gain: gain[3] = 64, band 3 = 4096, others 0 -> data_out = 512; then band 3 = −4097 -> data_out = −513 (rounds toward −inf).
- Saturation:
  - All bands 32767, all gains 255 -> data_out = 32767, clip pulse.
  - All bands −32768, all gains 255 -> data_out = −32768, clip pulse.
- Staggered and overrun:
  - Bands 0..14 strobe and band 15 strobes 5 cycles later -> frame starts the edge after band 15's capture, data_out correct.
  - Band 2 strobing twice before band 15 -> overrun = 1, the second band-2 value is used; overrun_clr -> overrun = 0.
- Back-to-back and snapshot collision:
  - A new full frame is delivered during MAC -> processed right after SAT, two valid_out pulses, both values correct.
  - band_valid[0] on the snapshot edge -> the next frame uses the new band-0 value.
- Reset mid-MAC: assert rst during MAC cycle 5 -> outputs 0, no valid_out; the gain written before reset reads as 128 afterwards (verified through mix result).
